top_beamformer: RTL and testbench

TOP_BEAMFORMER -- requirements
Module: top_beamformer

---
 rtl/top_beamformer.sv | 100 ++++++++++
 tb/tb_top_beamformer.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/top_beamformer.sv
// top_beamformer: delay-and-sum beamformer over an internal ramp source (BF_APOD_EN halves edge channels)
module top_beamformer #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_CH = 4,
  parameter int NUM_SAMPLES = 256
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      start,
  input  logic [DATA_WIDTH-1:0]                     x_f,
  input  logic [DATA_WIDTH-1:0]                     z_f,
  output logic signed [DATA_WIDTH+$clog2(NUM_CH)-1:0] beamformed_output,
  output logic                                      valid,
  output logic [1:0]                                debug_state
);
  localparam int AW = $clog2(NUM_SAMPLES);
  localparam int OW = DATA_WIDTH + $clog2(NUM_CH);
`ifdef BF_APOD_EN
  localparam bit APOD = 1'b1;
`else
  localparam bit APOD = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, ACCUM = 2'd2, DONE = 2'd3} state_t;
  state_t state, state_nx;
  logic [DATA_WIDTH-1:0] x_lat, z_lat;
  logic [AW-1:0] n;
  logic [AW-1:0] delay [NUM_CH];
  logic [AW-1:0] delay_nx [NUM_CH];
  logic signed [DATA_WIDTH:0] diff;
  logic [DATA_WIDTH:0] mag, tot;
  logic [AW-1:0] idx;
  logic signed [DATA_WIDTH-1:0] samp;
  logic signed [OW-1:0] sum;
  assign debug_state = state;
  // per-channel focusing delay: z plus lateral distance to the element at pitch 4, wrapped by truncation
  always_comb begin
    delay_nx = '{default: '0};
    diff = '0;
    mag = '0;
    tot = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      diff = $signed({x_lat[DATA_WIDTH-1], x_lat}) - $signed((DATA_WIDTH+1)'(i * 4));
      mag = diff[DATA_WIDTH] ? -diff : diff;
      tot = {1'b0, z_lat} + mag;
      delay_nx[i] = tot[AW-1:0];
    end
  end
  // sum of delayed ramp samples across channels; output is wide enough that it cannot overflow
  always_comb begin
    sum = '0;
    idx = '0;
    samp = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = n + delay[i];
      samp = $signed(DATA_WIDTH'(idx)) - $signed(DATA_WIDTH'(NUM_SAMPLES / 2));
      samp = (APOD && (i == 0 || i == NUM_CH - 1)) ? samp >>> 1 : samp;
      sum = sum + OW'(samp);
    end
  end
  // next-state: CALC and DONE are single cycles, ACCUM runs until the last sample index
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = start ? CALC : IDLE;
      CALC:    state_nx = ACCUM;
      ACCUM:   state_nx = (&n) ? DONE : ACCUM;
      default: state_nx = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else state <= state_nx;
  end
  // datapath: latch focus in IDLE, load delays in CALC, stream sums in ACCUM
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_lat <= '0;
      z_lat <= '0;
      n <= '0;
      delay <= '{default: '0};
      beamformed_output <= '0;
      valid <= 1'b0;
    end else begin
      valid <= (state == ACCUM);
      if (state == IDLE && start) begin
        x_lat <= x_f;
        z_lat <= z_f;
      end
      if (state == CALC) begin
        delay <= delay_nx;
        n <= '0;
      end
      if (state == ACCUM) begin
        beamformed_output <= sum;
        n <= n + AW'(1);
      end
    end
  end
endmodule

// File: tb/tb_top_beamformer.sv
// tb_top_beamformer: table-driven scans with a scoreboard queue checked against an independent model
module tb_top_beamformer;
  localparam int NS = 256;
  localparam int NC = 4;
`ifdef BF_APOD_EN
  localparam bit APOD = 1'b1;
`else
  localparam bit APOD = 1'b0;
`endif
  typedef struct {
    int x;
    int z;
    int first;
    int last;
  } vec_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic [15:0] x_f = '0;
  logic [15:0] z_f = '0;
  logic signed [17:0] bo;
  logic valid;
  logic [1:0] ds;
  int n_cmp = 0;
  int n_fail = 0;
  int q[$];
  int got[$];
  vec_t tbl[4];
  top_beamformer dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .x_f(x_f),
    .z_f(z_f),
    .beamformed_output(bo),
    .valid(valid),
    .debug_state(ds)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  function automatic int model(input int x, input int z, input int n);
    int s, d, v;
    s = 0;
    for (int c = 0; c < NC; c++) begin
      d = x - 4 * c;
      if (d < 0) d = -d;
      d = (z + d) & (NS - 1);
      v = ((n + d) & (NS - 1)) - NS / 2;
      if (APOD && (c == 0 || c == NC - 1)) v = v >>> 1;
      s += v;
    end
    return s;
  endfunction
  task automatic push_scan(input int x, input int z);
    for (int k = 0; k < NS; k++) q.push_back(model(x, z, k));
  endtask
  task automatic wait_state(input logic [1:0] s, input string nm);
    int k = 0;
    while (ds != s && k < 600) begin
      @(negedge clk);
      k++;
    end
    chk(nm, int'(ds), int'(s));
  endtask
  task automatic scan(input vec_t v);
    int cnt = 0;
    @(negedge clk);
    got.delete();
    x_f = 16'(v.x);
    z_f = 16'(v.z);
    start = 1'b1;
    push_scan(v.x, v.z);
    @(negedge clk);
    start = 1'b0;
    chk("calc_state", int'(ds), 1);
    @(negedge clk);
    while (ds == 2'd2 && cnt < 300) begin
      cnt++;
      @(negedge clk);
    end
    chk("accum_cycles", cnt, NS);
    chk("done_state", int'(ds), 3);
    chk("done_valid", int'(valid), 1);
    @(negedge clk);
    chk("idle_state", int'(ds), 0);
    chk("idle_valid", int'(valid), 0);
    chk("hold_output", int'(bo), v.last);
    chk("valid_count", got.size(), NS);
    chk("first_output", got[0], v.first);
    chk("last_output", got[NS-1], v.last);
    chk("queue_empty", q.size(), 0);
  endtask
  // scoreboard: every valid cycle must match the next expected sum
  always @(negedge clk) begin
    if (reset === 1'b1 && valid === 1'b1) begin
      got.push_back(int'(bo));
      if (q.size() == 0) chk("unexpected_valid", int'(valid), 0);
      else chk("sample", int'(bo), q.pop_front());
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end
  initial begin
    tbl[0] = '{0, 0, APOD ? -366 : -488, APOD ? -242 : -236};
    tbl[1] = '{0, 10, APOD ? -336 : -448, APOD ? -340 : -452};
    tbl[2] = '{-5, 3, APOD ? -342 : -456, APOD ? -346 : -460};
    tbl[3] = '{100, 250, APOD ? -120 : -160, APOD ? -124 : -164};
    x_f = 16'd7;
    start = 1'b1;
    #22;
    chk("reset_state", int'(ds), 0);
    chk("reset_valid", int'(valid), 0);
    chk("reset_output", int'(bo), 0);
    @(negedge clk);
    start = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_after_reset", int'(ds), 0);
    for (int i = 0; i < 4; i++) scan(tbl[i]);
    @(negedge clk);
    x_f = 16'(tbl[2].x);
    z_f = 16'(tbl[2].z);
    start = 1'b1;
    push_scan(tbl[2].x, tbl[2].z);
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    chk("mid_scan_state", int'(ds), 2);
    #2;
    reset = 1'b0;
    #1;
    chk("async_reset_state", int'(ds), 0);
    chk("async_reset_valid", int'(valid), 0);
    chk("async_reset_output", int'(bo), 0);
    q.delete();
    @(negedge clk);
    reset = 1'b1;
    got.delete();
    repeat (20) @(negedge clk);
    chk("no_valid_after_abort", got.size(), 0);
    chk("abort_idle", int'(ds), 0);
    got.delete();
    x_f = 16'(tbl[0].x);
    z_f = 16'(tbl[0].z);
    start = 1'b1;
    push_scan(tbl[0].x, tbl[0].z);
    wait_state(2'd2, "b2b_accum1");
    x_f = 16'(tbl[1].x);
    z_f = 16'(tbl[1].z);
    push_scan(tbl[1].x, tbl[1].z);
    wait_state(2'd3, "b2b_done1");
    @(negedge clk);
    chk("b2b_idle", int'(ds), 0);
    @(negedge clk);
    chk("b2b_calc", int'(ds), 1);
    start = 1'b0;
    wait_state(2'd3, "b2b_done2");
    @(negedge clk);
    wait_state(2'd0, "b2b_idle2");
    repeat (3) @(negedge clk);
    chk("b2b_count", got.size(), 2 * NS);
    chk("b2b_first1", got[0], tbl[0].first);
    chk("b2b_first2", got[NS], tbl[1].first);
    chk("b2b_queue_empty", q.size(), 0);
    chk("b2b_stays_idle", int'(ds), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
